// File: rtl/fp_status_pkg.sv
// fp_status_pkg
//   Shared types for the fp_mult result path.
//   - STAT_* : bit positions of the multiplier status byte (bit7 = overflow).
//   - fp_status_t : the status byte as named flags (MSB first).
//   - fp_result_t : one FIFO entry {z, status}.
//   - status_illegal() : flag combinations that a correct multiplier never
//     reports together.
package fp_status_pkg;

  localparam int unsigned STAT_OVF     = 7;
  localparam int unsigned STAT_UNF     = 6;
  localparam int unsigned STAT_ZERO    = 5;
  localparam int unsigned STAT_INF     = 4;
  localparam int unsigned STAT_NAN     = 3;
  localparam int unsigned STAT_TINY    = 2;
  localparam int unsigned STAT_HUGE    = 1;
  localparam int unsigned STAT_INEXACT = 0;

  localparam int unsigned NUM_FLAGS    = 8;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero_f;
    logic inf_f;
    logic nan_f;
    logic tiny_f;
    logic huge_f;
    logic inexact_f;
  } fp_status_t;

  typedef struct packed {
    logic [31:0] z;
    fp_status_t  status;
  } fp_result_t;

  // A result cannot be two of {zero, inf, nan} at once, nor both huge and tiny.
  function automatic logic status_illegal(input fp_status_t s);
    return (s.zero_f && s.inf_f) ||
           (s.zero_f && s.nan_f) ||
           (s.inf_f  && s.nan_f) ||
           (s.huge_f && s.tiny_f);
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo
//   Synchronous FIFO of fp_result_t entries.
//   Ports:
//     clk, rst (sync, active-low)
//     push, wdata     : write side; ignored when full
//     pop             : read side; ignored when empty
//     rdata           : head entry (all zeros while empty)
//     full, empty     : occupancy flags from registered count
//   Parameters: DEPTH (power of two, >= 2).
module fp_result_fifo
  import fp_status_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fp_result_t wdata,
  input  logic       pop,
  output fp_result_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fp_result_t       mem_q [DEPTH];
  fp_result_t       mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read straight from storage; gated to zero while empty so the
  // output is clean after reset even though storage itself is not reset.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fp_mult_result_collector.sv
// fp_mult_result_collector
//   Collects fp_mult_top results into a FIFO with valid/ready output and
//   keeps sticky exception flags plus per-flag saturating event counters.
//   Ports:
//     clk, rst (sync, active-low)
//     in_valid/in_ready, in_z[31:0], in_status[7:0] : upstream results
//     out_valid/out_ready, out_z, out_status          : buffered head
//     clr             : clears sticky, counters and status_err
//     sticky[7:0]     : OR of status of every accepted result
//     cnt_sel[2:0]    : counter select (index = status bit number)
//     cnt_value       : registered value of the selected counter
//     status_err      : sticky illegal-status indicator
//   Parameters: DEPTH (FIFO entries), CNT_W (counter width).
//   Build option: define FP_STATUS_CHECK_EN to enable the illegal-status
//   checker; otherwise status_err is tied low.
module fp_mult_result_collector
  import fp_status_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_z,
  input  logic [7:0]       in_status,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_z,
  output logic [7:0]       out_status,
  input  logic             out_ready,
  input  logic             clr,
  output logic [7:0]       sticky,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value,
  output logic             status_err
);

  fp_result_t in_entry;
  fp_result_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  logic [7:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q [NUM_FLAGS];
  logic [CNT_W-1:0] cnt_d [NUM_FLAGS];
  logic [CNT_W-1:0] cnt_value_q, cnt_value_d;

  always_comb begin
    in_entry.z      = in_z;
    in_entry.status = fp_status_t'(in_status);
  end

  // in_ready depends only on registered occupancy, so a full FIFO cannot
  // accept in the same cycle it is popped.
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fp_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_z      = head.z;
  assign out_status = head.status;

  // clr wins over history but not over a concurrent push: that push's
  // flags and counts survive as the new starting point.
  always_comb begin
    sticky_d = sticky_q;
    if (clr) begin
      sticky_d = push ? in_status : '0;
    end else if (push) begin
      sticky_d = sticky_q | in_status;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = (push && in_status[i]) ? CNT_W'(1) : '0;
      end else if (push && in_status[i] && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Readout samples the pre-update counter, giving one cycle of latency.
  always_comb begin
    cnt_value_d = cnt_q[cnt_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky_q    <= '0;
      cnt_value_q <= '0;
      for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sticky_q    <= sticky_d;
      cnt_value_q <= cnt_value_d;
      for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sticky    = sticky_q;
  assign cnt_value = cnt_value_q;

`ifdef FP_STATUS_CHECK_EN
  logic status_err_q, status_err_d;

  // Set takes priority over clr so an illegal push in the clr cycle is kept.
  always_comb begin
    status_err_d = clr ? 1'b0 : status_err_q;
    if (push && status_illegal(fp_status_t'(in_status))) begin
      status_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_err_q <= 1'b0;
    end else begin
      status_err_q <= status_err_d;
    end
  end

  assign status_err = status_err_q;
`else
  assign status_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mult_result_collector.sv
module tb_fp_mult_result_collector;

`ifdef FP_STATUS_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic        out_ready;
  logic        clr;
  logic [7:0]  sticky;
  logic [2:0]  cnt_sel;
  logic [15:0] cnt_value;
  logic        status_err;

  // Second instance with narrow counters for saturation.
  logic        in_valid2;
  logic [31:0] in_z2;
  logic [7:0]  in_status2;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_z2;
  logic [7:0]  out_status2;
  logic        out_ready2;
  logic        clr2;
  logic [7:0]  sticky2;
  logic [2:0]  cnt_sel2;
  logic [1:0]  cnt_value2;
  logic        status_err2;

  int total = 0;
  int bad   = 0;

  logic [39:0] sb_q[$];
  logic [7:0]  sticky_m;
  logic        err_m;

  always #5 clk = ~clk;

  fp_mult_result_collector #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_z(in_z), .in_status(in_status),
    .in_ready(in_ready), .out_valid(out_valid), .out_z(out_z), .out_status(out_status),
    .out_ready(out_ready), .clr(clr), .sticky(sticky), .cnt_sel(cnt_sel),
    .cnt_value(cnt_value), .status_err(status_err)
  );

  fp_mult_result_collector #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_z(in_z2), .in_status(in_status2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_z(out_z2), .out_status(out_status2),
    .out_ready(out_ready2), .clr(clr2), .sticky(sticky2), .cnt_sel(cnt_sel2),
    .cnt_value(cnt_value2), .status_err(status_err2)
  );

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic illegal(input logic [7:0] st);
    return (st[5] & st[4]) | (st[5] & st[3]) | (st[4] & st[3]) | (st[2] & st[1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a handshake seen at negedge completes at the next edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pop", {out_z, out_status}, 40'h0);
        if ({out_z, out_status} == 40'h0) begin
          bad++;
          $display("FAIL unexpected_pop: got empty-scoreboard pop expected none");
        end
      end else begin
        chk("pop_entry", {out_z, out_status}, sb_q.pop_front());
      end
    end
  end

  task automatic push(input logic [31:0] z, input logic [7:0] st,
                      input logic exp_acc, input logic do_clr);
    in_valid  = 1'b1;
    in_z      = z;
    in_status = st;
    clr       = do_clr;
    chk("in_ready", {39'h0, in_ready}, {39'h0, exp_acc});
    if (exp_acc) sb_q.push_back({z, st});
    if (do_clr) begin
      sticky_m = exp_acc ? st : 8'h00;
      err_m    = exp_acc && illegal(st) && EXP_CHK;
    end else if (exp_acc) begin
      sticky_m = sticky_m | st;
      err_m    = err_m | (illegal(st) & EXP_CHK);
    end
    tick();
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic pulse_clr();
    clr      = 1'b1;
    sticky_m = 8'h00;
    err_m    = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_left", 40'(sb_q.size()), 40'h0);
    chk("drained_valid", {39'h0, out_valid}, 40'h0);
  endtask

  task automatic read_cnt(input logic [2:0] sel, input logic [15:0] exp, input string name);
    cnt_sel = sel;
    tick();
    chk(name, {24'h0, cnt_value}, {24'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_z = '0; in_status = '0; out_ready = 1'b0;
    clr = 1'b0; cnt_sel = '0;
    in_valid2 = 1'b0; in_z2 = '0; in_status2 = '0; out_ready2 = 1'b1; clr2 = 1'b0; cnt_sel2 = '0;
    sticky_m = '0; err_m = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    chk("rst_out_valid", {39'h0, out_valid}, 40'h0);
    chk("rst_in_ready", {39'h0, in_ready}, 40'h1);
    chk("rst_out_word", {out_z, out_status}, 40'h0);
    chk("rst_sticky", {32'h0, sticky}, 40'h0);
    chk("rst_cnt_value", {24'h0, cnt_value}, 40'h0);
    chk("rst_status_err", {39'h0, status_err}, 40'h0);

    // Single result, one-cycle latency
    push(32'h3F800000, 8'h00, 1'b1, 1'b0);
    chk("t1_out_valid", {39'h0, out_valid}, 40'h1);
    chk("t1_out_z", {8'h0, out_z}, {8'h0, 32'h3F800000});
    chk("t1_sticky", {32'h0, sticky}, 40'h0);
    chk("t1_in_ready", {39'h0, in_ready}, 40'h1);
    drain();

    // Fill to DEPTH with consumer stalled
    out_ready = 1'b0;
    push(32'h11111111, 8'h01, 1'b1, 1'b0);
    push(32'h22222222, 8'h02, 1'b1, 1'b0);
    push(32'h33333333, 8'h04, 1'b1, 1'b0);
    push(32'h44444444, 8'h08, 1'b1, 1'b0);
    push(32'h55555555, 8'h40, 1'b0, 1'b0);   // full: ignored
    chk("full_sticky", {32'h0, sticky}, 40'h0F);
    chk("full_head_z", {8'h0, out_z}, {8'h0, 32'h11111111});
    tick();
    chk("held_head_z", {8'h0, out_z}, {8'h0, 32'h11111111});
    out_ready = 1'b1;
    push(32'h66666666, 8'h80, 1'b0, 1'b0);   // full FIFO does not accept while popping
    drain();
    chk("after_drain_in_ready", {39'h0, in_ready}, 40'h1);
    chk("after_drain_sticky", {32'h0, sticky}, {32'h0, sticky_m});

    // Sticky and counters
    pulse_clr();
    chk("clr_sticky", {32'h0, sticky}, 40'h0);
    push(32'hAAAA0001, 8'h81, 1'b1, 1'b0);
    push(32'hAAAA0002, 8'h10, 1'b1, 1'b0);
    chk("sticky_91", {32'h0, sticky}, 40'h91);
    read_cnt(3'd7, 16'd1, "cnt7_one");
    read_cnt(3'd4, 16'd1, "cnt4_one");
    read_cnt(3'd0, 16'd1, "cnt0_one");
    push(32'hAAAA0003, 8'h02, 1'b1, 1'b1);   // clr with push
    chk("clrpush_sticky", {32'h0, sticky}, 40'h02);
    read_cnt(3'd1, 16'd1, "clrpush_cnt1");
    read_cnt(3'd7, 16'd0, "clrpush_cnt7");
    read_cnt(3'd0, 16'd0, "clrpush_cnt0");
    drain();

    // Illegal-status checker
    push(32'hBBBB0001, 8'h30, 1'b1, 1'b0);
    chk("err_set", {39'h0, status_err}, {39'h0, EXP_CHK});
    push(32'hBBBB0002, 8'h00, 1'b1, 1'b0);
    chk("err_held", {39'h0, status_err}, {39'h0, err_m});
    pulse_clr();
    chk("err_cleared", {39'h0, status_err}, 40'h0);
    push(32'hBBBB0003, 8'h06, 1'b1, 1'b1);   // clr with illegal push
    chk("err_clr_push", {39'h0, status_err}, {39'h0, EXP_CHK});
    pulse_clr();
    push(32'hBBBB0004, 8'h29, 1'b1, 1'b0);   // zero+nan+inexact
    chk("err_zero_nan", {39'h0, status_err}, {39'h0, EXP_CHK});
    chk("sticky_29", {32'h0, sticky}, 40'h29);
    drain();

    // Counter saturation on the CNT_W=2 instance
    chk("sat_in_ready", {39'h0, in_ready2}, 40'h1);
    in_valid2 = 1'b1; in_status2 = 8'h01;
    for (int i = 0; i < 5; i++) tick();
    in_valid2 = 1'b0;
    cnt_sel2 = 3'd0;
    tick();
    chk("sat_cnt0", {38'h0, cnt_value2}, 40'h3);
    cnt_sel2 = 3'd1;
    tick();
    chk("sat_cnt1", {38'h0, cnt_value2}, 40'h0);

    // Reset with buffered entries
    out_ready = 1'b0;
    cnt_sel = 3'd0;
    push(32'hCCCC0001, 8'h01, 1'b1, 1'b0);
    push(32'hCCCC0002, 8'h01, 1'b1, 1'b0);
    chk("pre_rst_valid", {39'h0, out_valid}, 40'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sb_q.delete();
    sticky_m = '0; err_m = 1'b0;
    chk("mid_rst_out_valid", {39'h0, out_valid}, 40'h0);
    chk("mid_rst_in_ready", {39'h0, in_ready}, 40'h1);
    chk("mid_rst_sticky", {32'h0, sticky}, 40'h0);
    chk("mid_rst_err", {39'h0, status_err}, 40'h0);
    tick();
    chk("mid_rst_cnt_value", {24'h0, cnt_value}, 40'h0);
    chk("mid_rst_out_valid2", {39'h0, out_valid}, 40'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
